// File: rtl/dyno_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dyno_pkg: shared overlay geometry, video timing and fetch FSM states. |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package dyno_pkg;

    localparam int ROW_W    = 44;
    localparam int OVL_H    = 16;
    localparam int H_ACTIVE = 640;
    localparam int V_TOTAL  = 525;

    localparam int OVL_SCORE_LBL = 0;
    localparam int OVL_SCORE_DIG = 1;
    localparam int OVL_GAMEOVER  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/overlay_row_shifter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | overlay_row_shifter: horizontal window test and pixel bit select.     |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module overlay_row_shifter #(
    parameter int ROW_W = dyno_pkg::ROW_W
) (
    input  logic             valid,
    input  logic [10:0]      x,
    input  logic [10:0]      hc,
    input  logic [ROW_W-1:0] row,
    output logic             lit
);

    logic [11:0]      x_end;
    logic [11:0]      rel;
    logic [ROW_W-1:0] shifted;
    logic             in_win;

    // 12-bit end column: overlays near the right edge clip instead of wrapping
    assign x_end   = {1'b0, x} + 12'(ROW_W);
    assign in_win  = (hc >= x) && ({1'b0, hc} < x_end);
    assign rel     = {1'b0, hc} - {1'b0, x};
    assign shifted = row << rel;
    assign lit     = valid && in_win && shifted[ROW_W-1];

endmodule
`default_nettype wire

// File: rtl/overlay_row_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | overlay_row_scheduler: blanking-time glyph ROM fetch and pixel draw.  |
// | Option: OVERLAY_BLINK_EN blinks the last requester (16/16 frames).    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module overlay_row_scheduler #(
    parameter int NUM_REQ  = 3,
    parameter int ROW_W    = dyno_pkg::ROW_W,
    parameter int ROM_AW   = 11,
    parameter int OVL_H    = dyno_pkg::OVL_H,
    parameter int H_ACTIVE = dyno_pkg::H_ACTIVE,
    parameter int V_TOTAL  = dyno_pkg::V_TOTAL,
    parameter int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pix_en,
    input  logic [10:0]               hc,
    input  logic [10:0]               vc,
    input  logic [NUM_REQ-1:0]        req_en,
    input  logic [NUM_REQ*11-1:0]     req_x,
    input  logic [NUM_REQ*11-1:0]     req_y,
    input  logic [NUM_REQ*ROM_AW-1:0] req_base,
    output logic [ROM_AW-1:0]         rom_addr,
    input  logic [ROW_W-1:0]          rom_data,
    output logic                      pixel_on,
    output logic [ID_W-1:0]           hit_id,
    output logic                      busy
);

    import dyno_pkg::*;

    localparam logic [10:0]        LAST_LINE = 11'(V_TOTAL - 1);
    localparam logic [10:0]        BLANK_COL = 11'(H_ACTIVE);
    localparam logic [NUM_REQ-1:0] ALL_REQ   = {NUM_REQ{1'b1}};

    fetch_state_t      state;
    fetch_state_t      state_nx;
    logic [ID_W-1:0]   idx;
    logic [ID_W-1:0]   cur;
    logic [10:0]       nl;
    logic              trigger;
    logic              fetch_start;
    logic [NUM_REQ-1:0] hit;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] later;
    logic [ROM_AW-1:0] addr [NUM_REQ];
    logic [ID_W-1:0]   sel;
    logic              sel_found;
    logic [ROM_AW-1:0] sel_addr;
    logic [NUM_REQ-1:0] lit_raw;
    logic [NUM_REQ-1:0] lit;
    logic [ID_W-1:0]   first;

    assign trigger     = pix_en && (hc == BLANK_COL);
    assign fetch_start = (state == ST_IDLE) && trigger;
    assign busy        = (state != ST_IDLE);

    // idx is the next index to scan; cur is the requester whose row is in flight
    assign pending = hit & (ALL_REQ << idx);
    assign later   = hit & ((ALL_REQ << cur) << 1);

    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        sel_addr  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (pending[k]) begin
                sel       = ID_W'(k);
                sel_found = 1'b1;
                sel_addr  = addr[k];
            end
        end
    end

    always_comb begin
        state_nx = state;
        rom_addr = '0;
        unique case (state)
            ST_IDLE: begin
                if (trigger) state_nx = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (sel_found) begin
                    rom_addr = sel_addr;
                    state_nx = ST_CAPTURE;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                state_nx = (|later) ? ST_ISSUE : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            cur   <= '0;
            nl    <= '0;
        end else begin
            state <= state_nx;
            if (fetch_start) begin
                nl  <= (vc == LAST_LINE) ? 11'd0 : vc + 11'd1;
                idx <= '0;
            end
            if (state == ST_ISSUE && sel_found) cur <= sel;
            if (state == ST_CAPTURE) idx <= cur + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        logic [10:0]      y;
        logic [10:0]      off;
        logic [11:0]      y_end;
        logic             cap;
        logic             v;
        logic [10:0]      xp;
        logic [ROW_W-1:0] rb;

        assign y       = req_y[g*11 +: 11];
        assign y_end   = {1'b0, y} + 12'(OVL_H);
        assign off     = nl - y;
        assign hit[g]  = req_en[g] && (nl >= y) && ({1'b0, nl} < y_end);
        assign addr[g] = req_base[g*ROM_AW +: ROM_AW] + ROM_AW'(off);
        assign cap     = (state == ST_CAPTURE) && (cur == ID_W'(g));

        // x is latched with the row so a mid-line move waits for the next fetch
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v  <= 1'b0;
                xp <= '0;
                rb <= '0;
            end else if (fetch_start) begin
                v <= 1'b0;
            end else if (cap) begin
                v  <= 1'b1;
                xp <= req_x[g*11 +: 11];
                rb <= rom_data;
            end
        end

        overlay_row_shifter #(
            .ROW_W (ROW_W)
        ) u_shifter (
            .valid (v),
            .x     (xp),
            .hc    (hc),
            .row   (rb),
            .lit   (lit_raw[g])
        );
    end

`ifdef OVERLAY_BLINK_EN
    logic [4:0] frame_cnt;

    // counts at the last line's blanking, i.e. as vc wraps to line 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (pix_en && hc == BLANK_COL && vc == LAST_LINE) begin
            frame_cnt <= frame_cnt + 5'd1;
        end
    end
`endif

    always_comb begin
        lit = lit_raw;
`ifdef OVERLAY_BLINK_EN
        if (frame_cnt[4]) lit[NUM_REQ-1] = 1'b0;
`endif
        first = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (lit[k]) first = ID_W'(k);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_on <= 1'b0;
            hit_id   <= '0;
        end else if (pix_en) begin
            pixel_on <= (hc < BLANK_COL) && (|lit);
            hit_id   <= (hc < BLANK_COL) ? first : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_overlay_row_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_overlay_row_scheduler: directed fetch-sequence and draw-path bench.|
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_overlay_row_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic [10:0] hc;
    logic [10:0] vc;
    logic [2:0]  req_en;
    logic [32:0] req_x;
    logic [32:0] req_y;
    logic [32:0] req_base;
    logic [10:0] rom_addr;
    logic [43:0] rom_data;
    logic        pixel_on;
    logic [1:0]  hit_id;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    overlay_row_scheduler #(
        .NUM_REQ (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pix_en   (pix_en),
        .hc       (hc),
        .vc       (vc),
        .req_en   (req_en),
        .req_x    (req_x),
        .req_y    (req_y),
        .req_base (req_base),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .pixel_on (pixel_on),
        .hit_id   (hit_id),
        .busy     (busy)
    );

    // ROM row for address a carries a in both its top and bottom 11 bits
    function automatic logic [43:0] row_of(input logic [10:0] a);
        return {a, 22'h0, a};
    endfunction

    function automatic logic lit_of(input int h, input int x, input int a);
        logic [43:0] r;
        r = row_of(11'(a));
        if (h >= x && h < x + 44) return r[43 - (h - x)];
        return 1'b0;
    endfunction

    always @(posedge clk) rom_data <= row_of(rom_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic en, input int x, input int y, input int base);
        req_en[i]             = en;
        req_x[i*11 +: 11]     = 11'(x);
        req_y[i*11 +: 11]     = 11'(y);
        req_base[i*11 +: 11]  = 11'(base);
    endtask

    // leaves the bench at the negedge where the FSM sits in its first ISSUE
    task automatic trigger(input int v);
        @(negedge clk);
        hc = 11'd640; vc = 11'(v); pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    task automatic draw_chk(input string tag, input int h, input logic e_on, input int e_id);
        @(negedge clk);
        hc = 11'(h); vc = 11'd300; pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        check({tag, "_on"}, 32'(pixel_on), 32'(e_on));
        if (e_on) check({tag, "_id"}, 32'(hit_id), 32'(e_id));
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0; hc = '0; vc = '0;
        req_en = '0; req_x = '0; req_y = '0; req_base = '0;
        repeat (3) @(negedge clk);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_pixel_on", 32'(pixel_on), 32'd0);
        check("rst_hit_id",   32'(hit_id),   32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        rst = 1'b0;

        // single requester, line 101 blanking fetches row 2
        set_req(0, 1'b1, 10, 100, 0);
        trigger(101);
        check("t1_busy_c1", 32'(busy), 32'd1);
        check("t1_addr",    32'(rom_addr), 32'd2);
        @(negedge clk);
        check("t1_busy_c2", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_busy_c3", 32'(busy), 32'd0);
        draw_chk("t1_h9",  9,  1'b0, 0);
        draw_chk("t1_h18", 18, 1'b0, 0);
        draw_chk("t1_h19", 19, 1'b1, 0);
        draw_chk("t1_h20", 20, 1'b0, 0);
        draw_chk("t1_h52", 52, 1'b1, 0);
        draw_chk("t1_h54", 54, 1'b0, 0);
        for (int h = 8; h < 56; h++) draw_chk("t1_scan", h, lit_of(h, 10, 2), 0);

        // three requesters on one line: rows 5, 7, 10 of each overlay
        set_req(0, 1'b1, 100, 200, 100);
        set_req(1, 1'b1, 100, 198, 300);
        set_req(2, 1'b1, 100, 195, 500);
        trigger(204);
        check("t2_addr0", 32'(rom_addr), 32'd105);
        @(negedge clk);
        check("t2_cap0_addr", 32'(rom_addr), 32'd0);
        check("t2_cap0_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t2_addr1", 32'(rom_addr), 32'd307);
        @(negedge clk);
        @(negedge clk);
        check("t2_addr2", 32'(rom_addr), 32'd510);
        @(negedge clk);
        check("t2_busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        check("t2_busy_done", 32'(busy), 32'd0);
        draw_chk("t2_h105", 105, 1'b1, 0);
        draw_chk("t2_h106", 106, 1'b1, 1);
        draw_chk("t2_h103", 103, 1'b1, 2);
        draw_chk("t2_h104", 104, 1'b1, 0);
        draw_chk("t2_h101", 101, 1'b0, 0);
        for (int h = 98; h < 146; h++) begin
            logic l0, l1, l2;
            l0 = lit_of(h, 100, 105);
            l1 = lit_of(h, 100, 307);
            l2 = lit_of(h, 100, 510);
            draw_chk("t2_scan", h, l0 | l1 | l2, l0 ? 0 : (l1 ? 1 : 2));
        end

        // requester 1 disabled, plus a re-trigger while busy that must be ignored
        req_en = 3'b101;
        trigger(204);
        check("t3_addr0", 32'(rom_addr), 32'd105);
        @(negedge clk);
        check("t3_cap0_addr", 32'(rom_addr), 32'd0);
        hc = 11'd640; vc = 11'd0; pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        check("t3_addr2", 32'(rom_addr), 32'd510);
        @(negedge clk);
        check("t3_busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        check("t3_busy_done", 32'(busy), 32'd0);
        draw_chk("t3_h106", 106, 1'b1, 2);
        draw_chk("t3_h105", 105, 1'b1, 0);

        // frame wrap: line 524 blanking fetches row 0 for req_y = 0
        req_en = 3'b001;
        set_req(0, 1'b1, 0, 0, 40);
        trigger(524);
        check("t4_addr", 32'(rom_addr), 32'd40);
        @(negedge clk);
        @(negedge clk);
        check("t4_busy_done", 32'(busy), 32'd0);
        req_x[10:0] = 11'd300;
        draw_chk("t4_h5", 5, 1'b1, 0);
        draw_chk("t4_h6", 6, 1'b0, 0);
        draw_chk("t4_h7", 7, 1'b1, 0);

        // reset in the middle of a fetch, then recovery at the next blanking
        set_req(0, 1'b1, 10, 100, 0);
        trigger(101);
        check("t5_addr", 32'(rom_addr), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy_rst", 32'(busy), 32'd0);
        check("t5_addr_rst", 32'(rom_addr), 32'd0);
        check("t5_pix_rst",  32'(pixel_on), 32'd0);
        draw_chk("t5_h19_dark", 19, 1'b0, 0);
        trigger(102);
        check("t5_addr_next", 32'(rom_addr), 32'd3);
        @(negedge clk);
        @(negedge clk);
        check("t5_busy_done", 32'(busy), 32'd0);
        draw_chk("t5_h19", 19, 1'b1, 0);
        draw_chk("t5_h20", 20, 1'b1, 0);
        draw_chk("t5_h21", 21, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
